wb_stage: RTL

Writeback stage of the simple RISC-V core: the stage directly upstream of the register file, and the only driver of its write port. It accepts retiring instructions from the execute/memory stage over a valid/ready handshake. It waits for AXI-lite read data on loads, aligns and sign-extends that data, and issues a single registered write per instruction. It also exports a same-cycle forwarding path and a pending-load indication for the hazard unit.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/wb_stage_if.sv | 68 ++++++
 rtl/load_align.sv | 51 +++++
 rtl/wb_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the writeback stage of the simple RISC-V core:
//   writeback-source select encoding, load funct3 codes and the writeback
//   FSM state type.
// ---------------------------------------------------------------------------
package riscv_pkg;

  // Result source for the register file write.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Load funct3 codes.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Writeback FSM states.
  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_LOAD_WAIT = 2'd1,
    WB_DRAIN     = 2'd2
  } wb_state_t;

  function automatic logic is_load(input logic [1:0] wb_sel);
    return wb_sel == WB_MEM;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
//   Bundles every signal of the writeback stage except clk/rst.
//   Groups:
//     in_*        retiring instruction from execute/memory (valid/ready)
//     flush       kills the pending or offered instruction
//     mem_*       AXI-lite R channel (valid/ready)
//     RegWrite, rd_addr, write_data   register file write port
//     fwd_*       bypass copies of the write port
//     load_*      hazard-unit indications
//     dbg_state   current FSM state, for observation only
//   Handshakes: a transfer happens on a rising clk edge where both valid and
//   ready are high; valid must not depend on ready.
//   Modports: master = upstream / memory / testbench side, slave = wb_stage.
// ---------------------------------------------------------------------------
interface wb_stage_if
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_reg_write;
  logic [4:0]      in_rd_addr;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic            flush;

  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic [1:0]      mem_rresp;
  logic            mem_rready;

  logic            RegWrite;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] write_data;

  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  logic            load_pending;
  logic [4:0]      load_rd;
  logic            load_err;

  wb_state_t       dbg_state;

  modport master (
    output in_valid, in_reg_write, in_rd_addr, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, flush,
           mem_rvalid, mem_rdata, mem_rresp,
    input  in_ready, mem_rready, RegWrite, rd_addr, write_data,
           fwd_valid, fwd_rd, fwd_data, load_pending, load_rd, load_err,
           dbg_state
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd_addr, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, flush,
           mem_rvalid, mem_rdata, mem_rresp,
    output in_ready, mem_rready, RegWrite, rd_addr, write_data,
           fwd_valid, fwd_rd, fwd_data, load_pending, load_rd, load_err,
           dbg_state
  );

endinterface

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Purely combinational load data formatter.
//   Ports:
//     funct3_i      load type (LB/LH/LW/LBU/LHU)
//     offset_i      byte address bits [1:0]
//     rdata_i       raw 32-bit read word
//     data_o        aligned, sign/zero-extended result
//     misaligned_o  access is misaligned or funct3 is not a load code
// ---------------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Bring the addressed byte / halfword down to bit 0.
  assign byte_sh = rdata_i >> {offset_i, 3'b000};
  assign half_sh = rdata_i >> {offset_i[1], 4'b0000};

  always_comb begin
    data_o       = rdata_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      LB:  data_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LBU: data_o = {24'd0, byte_sh[7:0]};
      LH: begin
        data_o       = {{16{half_sh[15]}}, half_sh[15:0]};
        misaligned_o = offset_i[0];
      end
      LHU: begin
        data_o       = {16'd0, half_sh[15:0]};
        misaligned_o = offset_i[0];
      end
      LW: begin
        data_o       = rdata_i;
        misaligned_o = (offset_i != 2'b00);
      end
      // Unused funct3 codes are reported like a misaligned access.
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   Writeback stage: sole driver of the register file write port.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   wb_stage_if.slave: instruction input, flush, AXI-lite R channel,
//           regfile write port, forwarding copies, hazard indications and
//           the debug state.
//   Non-load results are registered in the accept cycle. Loads wait in
//   LOAD_WAIT for the R beat; a flush while waiting moves to DRAIN so the
//   outstanding beat is still consumed and discarded.
// ---------------------------------------------------------------------------
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);

  localparam logic [1:0] S_IDLE      = WB_IDLE;
  localparam logic [1:0] S_LOAD_WAIT = WB_LOAD_WAIT;
  localparam logic [1:0] S_DRAIN     = WB_DRAIN;

  logic [1:0]      state_q, state_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic            load_err_q, load_err_d;
  logic [4:0]      load_rd_q, load_rd_d;
  logic            load_we_q, load_we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      offset_q, offset_d;

  logic            accept;
  logic [31:0]     aligned_data;
  logic            misaligned;
  logic            load_fail;

  load_align u_load_align (
    .funct3_i     (funct3_q),
    .offset_i     (offset_q),
    .rdata_i      (bus.mem_rdata),
    .data_o       (aligned_data),
    .misaligned_o (misaligned)
  );

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.mem_rready = (state_q == S_LOAD_WAIT) || (state_q == S_DRAIN);
  assign accept         = bus.in_valid && bus.in_ready && !bus.flush;
  assign load_fail      = (bus.mem_rresp != 2'b00) || misaligned;

  always_comb begin
    state_d      = state_q;
    reg_write_d  = 1'b0;
    load_err_d   = 1'b0;
    rd_addr_d    = rd_addr_q;
    write_data_d = write_data_q;
    load_rd_d    = load_rd_q;
    load_we_d    = load_we_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_load(bus.in_wb_sel)) begin
            load_rd_d = bus.in_rd_addr;
            load_we_d = bus.in_reg_write;
            funct3_d  = bus.in_funct3;
            offset_d  = bus.in_alu_result[1:0];
            state_d   = S_LOAD_WAIT;
          end else begin
            rd_addr_d    = bus.in_rd_addr;
            write_data_d = (bus.in_wb_sel == WB_PC4) ? bus.in_pc_plus4
                                                     : bus.in_alu_result;
            reg_write_d  = bus.in_reg_write && (bus.in_rd_addr != 5'd0);
          end
        end
      end
      S_LOAD_WAIT: begin
        if (bus.mem_rvalid) begin
          // A flush on the beat cycle drops the data silently.
          if (!bus.flush) begin
            rd_addr_d    = load_rd_q;
            write_data_d = aligned_data;
            reg_write_d  = !load_fail && load_we_q && (load_rd_q != 5'd0);
            load_err_d   = load_fail;
          end
          state_d = S_IDLE;
        end else if (bus.flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      reg_write_q  <= 1'b0;
      rd_addr_q    <= 5'd0;
      write_data_q <= '0;
      load_err_q   <= 1'b0;
      load_rd_q    <= 5'd0;
      load_we_q    <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= reg_write_d;
      rd_addr_q    <= rd_addr_d;
      write_data_q <= write_data_d;
      load_err_q   <= load_err_d;
      load_rd_q    <= load_rd_d;
      load_we_q    <= load_we_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
    end
  end

  assign bus.RegWrite     = reg_write_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.write_data   = write_data_q;
  assign bus.fwd_valid    = reg_write_q;
  assign bus.fwd_rd       = rd_addr_q;
  assign bus.fwd_data     = write_data_q;
  assign bus.load_pending = (state_q == S_LOAD_WAIT);
  assign bus.load_rd      = load_rd_q;
  assign bus.load_err     = load_err_q;
  assign bus.dbg_state    = wb_state_t'(state_q);

endmodule
